tiny16_io_timer: RTL

TINY16_IO_TIMER -- requirements
Module: tiny16_io_timer

---
 rtl/tiny16_io_pkg.sv | 27 ++
 rtl/tiny16_prescaler.sv | 35 +++
 rtl/tiny16_io_timer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/tiny16_io_pkg.sv
// Shared definitions for the tiny16 I/O timer: register offsets inside the
// 8-byte I/O window, CTRL bit positions and the bus handshake state encoding.
package tiny16_io_pkg;

  // Register offsets (address[2:0])
  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_STATUS   = 3'd1;
  localparam logic [2:0] OFF_RELOAD   = 3'd2;
  localparam logic [2:0] OFF_COUNT    = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;
  localparam logic [2:0] OFF_IRQCNT   = 3'd5;

  // CTRL bit indices
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  // STATUS bit indices
  localparam int STATUS_EXP = 0;

  // Bus handshake: IDLE waits for a hit, ACK is the single wait/complete cycle
  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/tiny16_prescaler.sv
// Prescaler for the I/O timer: counts 0..limit while enabled and emits a
// one-cycle tick in the cycle the count sits at limit, then restarts at 0.
// A limit of 0 therefore ticks every enabled cycle.
module tiny16_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] limit,
  output logic        tick
);

  logic [15:0] cnt;
  logic        at_limit;

  // ">=" rather than "==" so that lowering limit below the running count
  // cannot make the prescaler run the long way round through 16'hFFFF.
  assign at_limit = (cnt >= limit);
  assign tick     = en & ~clr & at_limit;

  // Prescale counter: clear has priority, otherwise advance only while enabled
  always_ff @(posedge clk) begin
    // NOTE: state registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values of the others, exactly like hardware.
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (at_limit) cnt <= '0;
      else          cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/tiny16_io_timer.sv
// Memory-mapped down-counting timer for the tiny16 CPU. Decodes an 8-byte I/O
// window at BASE_ADDR, answers every hit with one wait state, and raises a
// level interrupt when the counter expires. Also counts ISR entries.
module tiny16_io_timer
  import tiny16_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  address,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic        mem_valid,
  input  logic        nwr,
  output logic        mem_ready,
  output logic        interrupt,
  input  logic        in_interrupt
);

  bus_state_e  state, state_next;
  logic        hit;
  logic        accept;
  logic [2:0]  offset;
  logic        wr;
  logic [15:0] read_mux;

  logic        ctrl_en, ctrl_auto, ctrl_ie;
  logic        exp_flag;
  logic [15:0] reload;
  logic [15:0] count;
  logic [15:0] prescale;
  logic [15:0] irqcnt;
  logic        in_interrupt_q;

  logic        wr_ctrl, wr_status, wr_reload, wr_count, wr_prescale;
  logic        presc_clr;
  logic        tick;
  logic        tick_eff;
  logic        exp_set;

  assign hit    = mem_valid & (address[7:3] == BASE_ADDR[7:3]);
  assign offset = address[2:0];

  // mem_ready is a pure decode of the state flop, so it is registered and
  // high exactly for the ACK cycle.
  assign mem_ready = (state == BUS_ACK);

  // Bus state register
  always_ff @(posedge clk) begin
    if (reset) state <= BUS_IDLE;
    else       state <= state_next;
  end

  // Bus next-state: a hit is only taken from IDLE, ACK always returns to IDLE
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next = state;
    accept     = 1'b0;
    case (state)
      BUS_IDLE: begin
        if (hit) begin
          accept     = 1'b1;
          state_next = BUS_ACK;
        end
      end
      BUS_ACK:  state_next = BUS_IDLE;
      default:  state_next = BUS_IDLE;
    endcase
  end

  // Write strobes, all qualified by the IDLE->ACK edge
  assign wr          = accept & ~nwr;
  assign wr_ctrl     = wr & (offset == OFF_CTRL);
  assign wr_status   = wr & (offset == OFF_STATUS);
  assign wr_reload   = wr & (offset == OFF_RELOAD);
  assign wr_count    = wr & (offset == OFF_COUNT);
  assign wr_prescale = wr & (offset == OFF_PRESCALE);

  // Turning EN on restarts the prescale period from zero.
  assign presc_clr = wr_ctrl & wdata[CTRL_EN] & ~ctrl_en;

  tiny16_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_en),
    .clr   (presc_clr),
    .limit (prescale),
    .tick  (tick)
  );

  // A CPU write to COUNT in the same cycle swallows the tick entirely.
  assign tick_eff = tick & ~wr_count;
  assign exp_set  = tick_eff & (count == 16'd0);

  // Read data mux over the register map; unmapped offsets read as zero
  always_comb begin
    read_mux = 16'd0;
    case (offset)
      OFF_CTRL:     read_mux = {13'd0, ctrl_ie, ctrl_auto, ctrl_en};
      OFF_STATUS:   read_mux = {15'd0, exp_flag};
      OFF_RELOAD:   read_mux = reload;
      OFF_COUNT:    read_mux = count;
      OFF_PRESCALE: read_mux = prescale;
      OFF_IRQCNT:   read_mux = irqcnt;
      default:      read_mux = 16'd0;
    endcase
  end

  // Read data register: only carries data during ACK of a read, else zero
  always_ff @(posedge clk) begin
    if (reset)                rdata <= 16'd0;
    else if (accept && nwr)   rdata <= read_mux;
    else                      rdata <= 16'd0;
  end

  // CTRL register: a CPU write wins over auto-disable on one-shot expiry
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en   <= 1'b0;
      ctrl_auto <= 1'b0;
      ctrl_ie   <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en   <= wdata[CTRL_EN];
      ctrl_auto <= wdata[CTRL_AUTO];
      ctrl_ie   <= wdata[CTRL_IE];
    end else if (exp_set && !ctrl_auto) begin
      ctrl_en   <= 1'b0;
    end
  end

  // EXP flag: setting has priority over write-1-to-clear
  always_ff @(posedge clk) begin
    if (reset)                                exp_flag <= 1'b0;
    else if (exp_set)                         exp_flag <= 1'b1;
    else if (wr_status && wdata[STATUS_EXP])  exp_flag <= 1'b0;
  end

  // RELOAD and PRESCALE plain read/write registers
  always_ff @(posedge clk) begin
    if (reset) begin
      reload   <= 16'd0;
      prescale <= 16'd0;
    end else begin
      if (wr_reload)   reload   <= wdata;
      if (wr_prescale) prescale <= wdata;
    end
  end

  // Down counter: CPU load, else decrement per tick, reload on expiry in AUTO
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 16'd0;
    end else if (wr_count) begin
      count <= wdata;
    end else if (tick_eff) begin
      if (count != 16'd0) count <= count - 16'd1;
      else if (ctrl_auto) count <= reload;
    end
  end

  // Interrupt request, one cycle behind EXP & IE
  always_ff @(posedge clk) begin
    if (reset) interrupt <= 1'b0;
    else       interrupt <= exp_flag & ctrl_ie;
  end

  // in_interrupt edge detector
  always_ff @(posedge clk) begin
    if (reset) in_interrupt_q <= 1'b0;
    else       in_interrupt_q <= in_interrupt;
  end

  // ISR entry counter; only assigned on reset or a rising edge, wraps naturally
  always_ff @(posedge clk) begin
    if (reset)                               irqcnt <= 16'd0;
    else if (in_interrupt && !in_interrupt_q) irqcnt <= irqcnt + 16'd1;
  end

endmodule
